// File: rtl/mdio_pkg.sv
// mdio_pkg: shared frame constants, register map and FSM states for the MDIO PHY responder
package mdio_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA_RD,
    S_RD_DATA,
    S_TA_WR,
    S_WR_DATA,
    S_IGNORE
  } state_e;

  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] ST_PATTERN = 2'b01;
  localparam logic [1:0] TA_WRITE   = 2'b10;

  localparam logic [4:0] REG_CTRL = 5'd0;
  localparam logic [4:0] REG_STAT = 5'd1;
  localparam logic [4:0] REG_ID1  = 5'd2;
  localparam logic [4:0] REG_ID2  = 5'd3;

  localparam logic [15:0] REG_STAT_VAL = 16'h782D;

  // Bits left in a frame after REGAD: two turnaround bits plus sixteen data bits.
  localparam logic [4:0] TAIL_BITS = 5'd18;
  localparam logic [4:0] DATA_BITS = 5'd16;

endpackage

// File: rtl/mdc_edge_sync.sv
// mdc_edge_sync: brings MDC and MDIO into the system clock domain and flags each MDC rising edge
module mdc_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic mdc_i,
  input  logic mdio_i,
  output logic mdc_rise_o,
  output logic mdio_smp_o
);

  logic [2:0] mdc_q;
  logic [1:0] mdio_q;

  // Two-stage synchronizers; the third MDC stage only serves edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mdc_q  <= 3'b000;
      mdio_q <= 2'b11;
    end else begin
      mdc_q  <= {mdc_q[1:0], mdc_i};
      mdio_q <= {mdio_q[0], mdio_i};
    end
  end

  assign mdc_rise_o = mdc_q[1] & ~mdc_q[2];
  assign mdio_smp_o = mdio_q[1];

endmodule

// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder: Clause-22 MDIO slave emulating a 32 x 16-bit PHY register file (optional MDIO_PREAMBLE_SUPPRESS_EN)
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter logic [15:0] PHY_ID1      = 16'h0007,
  parameter logic [15:0] PHY_ID2      = 16'hC0F1,
  parameter int          PREAMBLE_LEN = 32
) (
  input  logic        AXI_Clk,
  input  logic        AXI_Rstn,
  input  logic        MDC_In,
  input  logic        MDIO_I,
  output logic        MDIO_O,
  output logic        MDIO_T,
  output logic [15:0] Ctrl_Reg,
  output logic        Wr_Strb,
  output logic [4:0]  Wr_Addr,
  output logic        Frame_Err
);
  import mdio_pkg::*;

  localparam int PW = $clog2(PREAMBLE_LEN + 1);
  localparam logic [PW-1:0] PRE_FULL = PW'(PREAMBLE_LEN);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam logic [PW-1:0] PRE_MIN  = PRE_ONE;
  localparam logic [15:0]   STAT_VAL = REG_STAT_VAL | 16'h0040;
`else
  localparam logic [PW-1:0] PRE_MIN  = PRE_FULL;
  localparam logic [15:0]   STAT_VAL = REG_STAT_VAL;
`endif

  logic          rise, bit_in;
  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [4:0]    phy_q, phy_d;
  logic [4:0]    reg_q, reg_d;
  logic [15:0]   sr_q, sr_d;
  logic          mdio_o_q, mdio_o_d;
  logic          mdio_t_q, mdio_t_d;
  logic          wr_strb_q, wr_strb_d;
  logic [4:0]    wr_addr_q, wr_addr_d;
  logic          frame_err_q, frame_err_d;
  logic          srst_q;
  logic [15:0]   regs_q [32];
  logic [4:0]    ra;
  logic [15:0]   rd_val;

  mdc_edge_sync u_sync (
    .clk_i      (AXI_Clk),
    .rst_ni     (AXI_Rstn),
    .mdc_i      (MDC_In),
    .mdio_i     (MDIO_I),
    .mdc_rise_o (rise),
    .mdio_smp_o (bit_in)
  );

  // Register address completes with the bit arriving on the last REGAD edge.
  assign ra = {reg_q[3:0], bit_in};

  // Read mux: ID and status registers are constants, everything else comes from the bank.
  always_comb begin
    rd_val = ra == REG_STAT ? STAT_VAL :
             ra == REG_ID1  ? PHY_ID1  :
             ra == REG_ID2  ? PHY_ID2  : regs_q[ra];
  end

  // Frame decoder: advances one bit per synchronized MDC rising edge.
  always_comb begin
    state_d     = state_q;
    pre_d       = pre_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    phy_d       = phy_q;
    reg_d       = reg_q;
    sr_d        = sr_q;
    mdio_o_d    = mdio_o_q;
    mdio_t_d    = mdio_t_q;
    wr_strb_d   = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = 1'b0;
    if (rise) begin
      case (state_q)
        S_IDLE: begin
          if (bit_in != ST_PATTERN[1]) begin
            pre_d = (pre_q == PRE_FULL) ? pre_q : pre_q + PRE_ONE;
          end else begin
            pre_d = '0;
            if (pre_q >= PRE_MIN) state_d = S_ST;
          end
        end
        S_ST: begin
          state_d = (bit_in == ST_PATTERN[0]) ? S_OP : S_IDLE;
          cnt_d   = '0;
        end
        S_OP: begin
          op_d  = {op_q[0], bit_in};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd1) begin
            state_d = S_PHYAD;
            cnt_d   = '0;
          end
        end
        S_PHYAD: begin
          phy_d = {phy_q[3:0], bit_in};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd4) begin
            state_d = S_REGAD;
            cnt_d   = '0;
          end
        end
        S_REGAD: begin
          reg_d = ra;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd4) begin
            cnt_d = '0;
            if (phy_q != PHY_ADDR) begin
              state_d = S_IGNORE;
              cnt_d   = TAIL_BITS;
            end else if (op_q == OP_READ) begin
              state_d = S_TA_RD;
              sr_d    = rd_val;
            end else if (op_q == OP_WRITE) begin
              state_d = S_TA_WR;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_IGNORE;
              cnt_d       = TAIL_BITS;
            end
          end
        end
        S_TA_RD: begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd1) begin
            mdio_t_d = 1'b0;
            mdio_o_d = 1'b0;
            state_d  = S_RD_DATA;
            cnt_d    = '0;
          end
        end
        S_RD_DATA: begin
          if (cnt_q == DATA_BITS) begin
            mdio_t_d = 1'b1;
            mdio_o_d = 1'b1;
            state_d  = S_IDLE;
            cnt_d    = '0;
          end else begin
            mdio_o_d = sr_q[15];
            sr_d     = {sr_q[14:0], 1'b0};
            cnt_d    = cnt_q + 5'd1;
          end
        end
        S_TA_WR: begin
          sr_d  = {sr_q[14:0], bit_in};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd1) begin
            cnt_d = '0;
            if ({sr_q[0], bit_in} == TA_WRITE) begin
              state_d = S_WR_DATA;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_IGNORE;
              cnt_d       = DATA_BITS;
            end
          end
        end
        S_WR_DATA: begin
          sr_d  = {sr_q[14:0], bit_in};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == DATA_BITS - 5'd1) begin
            wr_strb_d = 1'b1;
            wr_addr_d = reg_q;
            state_d   = S_IDLE;
            cnt_d     = '0;
          end
        end
        S_IGNORE: begin
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Decoder state and pad/strobe outputs; reset releases the pad immediately.
  always_ff @(posedge AXI_Clk or negedge AXI_Rstn) begin
    if (!AXI_Rstn) begin
      state_q     <= S_IDLE;
      pre_q       <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      phy_q       <= '0;
      reg_q       <= '0;
      sr_q        <= '0;
      mdio_o_q    <= 1'b1;
      mdio_t_q    <= 1'b1;
      wr_strb_q   <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      phy_q       <= phy_d;
      reg_q       <= reg_d;
      sr_q        <= sr_d;
      mdio_o_q    <= mdio_o_d;
      mdio_t_q    <= mdio_t_d;
      wr_strb_q   <= wr_strb_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Register bank: commits writes, then applies a pending soft reset one cycle later.
  always_ff @(posedge AXI_Clk or negedge AXI_Rstn) begin
    if (!AXI_Rstn) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      srst_q <= 1'b0;
    end else if (srst_q) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      srst_q <= 1'b0;
    end else if (wr_strb_d) begin
      if (reg_q == REG_CTRL || reg_q > REG_ID2) regs_q[reg_q] <= sr_d;
      srst_q <= (reg_q == REG_CTRL) && sr_d[15];
    end
  end

  assign MDIO_O    = mdio_o_q;
  assign MDIO_T    = mdio_t_q;
  assign Ctrl_Reg  = regs_q[0];
  assign Wr_Strb   = wr_strb_q;
  assign Wr_Addr   = wr_addr_q;
  assign Frame_Err = frame_err_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// tb_mdio_phy_responder: randomized MDIO master against an array-based register-file model
module tb_mdio_phy_responder;

  localparam logic [4:0] PHY = 5'd1;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam int          PRE_REQ = 1;
  localparam logic [15:0] STAT    = 16'h786D;
`else
  localparam int          PRE_REQ = 32;
  localparam logic [15:0] STAT    = 16'h782D;
`endif

  logic        AXI_Clk = 1'b0;
  logic        AXI_Rstn = 1'b0;
  logic        MDC_In = 1'b0;
  logic        MDIO_I = 1'b1;
  logic        MDIO_O, MDIO_T, Wr_Strb, Frame_Err;
  logic [15:0] Ctrl_Reg;
  logic [4:0]  Wr_Addr;

  int          n_chk = 0;
  int          n_bad = 0;
  int          n_strb = 0;
  int          n_err = 0;
  logic [4:0]  last_wa = '0;
  logic [15:0] mregs [32];

  mdio_phy_responder dut (
    .AXI_Clk   (AXI_Clk),
    .AXI_Rstn  (AXI_Rstn),
    .MDC_In    (MDC_In),
    .MDIO_I    (MDIO_I),
    .MDIO_O    (MDIO_O),
    .MDIO_T    (MDIO_T),
    .Ctrl_Reg  (Ctrl_Reg),
    .Wr_Strb   (Wr_Strb),
    .Wr_Addr   (Wr_Addr),
    .Frame_Err (Frame_Err)
  );

  always #5 AXI_Clk = ~AXI_Clk;

  always @(negedge AXI_Clk) begin
    if (Wr_Strb) begin
      n_strb = n_strb + 1;
      last_wa = Wr_Addr;
    end
    if (Frame_Err) n_err = n_err + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_rd(input logic [4:0] a);
    return a == 5'd1 ? STAT : a == 5'd2 ? 16'h0007 : a == 5'd3 ? 16'hC0F1 : mregs[a];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
  endfunction

  function automatic void model_wr(input logic [4:0] a, input logic [15:0] d);
    if (a == 5'd0 && d[15]) model_clear();
    else if (a == 5'd0 || a > 5'd3) mregs[a] = d;
  endfunction

  task automatic mdc_bit(input logic b, output logic t, output logic o);
    MDC_In = 1'b0;
    MDIO_I = b;
    #(50 + (($urandom_range(0, 63) == 0) ? 600 : 0));
    t = MDIO_T;
    o = MDIO_O;
    MDC_In = 1'b1;
    #50;
  endtask

  task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                       input logic [1:0] ta, input logic [15:0] wd, input int rst_at);
    logic [13:0] hdr;
    logic [19:0] tail, ts, os;
    logic [15:0] got, exp;
    logic        acc, is_rd, is_wr, hit_rst, exp_s, exp_e, t, o;
    int          s0, e0;
    hdr = {2'b01, op, phy, ra};
    is_rd = op == 2'b10;
    is_wr = op == 2'b01;
    tail = is_wr ? {ta, wd, 2'b11} : 20'hFFFFF;
    acc = pre >= PRE_REQ && phy == PHY;
    hit_rst = 1'b0;
    exp = model_rd(ra);
    s0 = n_strb;
    e0 = n_err;
    if (pre < PRE_REQ) mdc_bit(1'b0, t, o);
    repeat (pre) mdc_bit(1'b1, t, o);
    for (int i = 13; i >= 0; i--) mdc_bit(hdr[i], t, o);
    for (int i = 0; i < 20; i++) begin
      mdc_bit(tail[19-i], t, o);
      ts[i] = t;
      os[i] = o;
      if (i == rst_at) begin
        chk("rst_drv_t", 32'(MDIO_T), 32'd0);
        AXI_Rstn = 1'b0;
        #1;
        chk("rst_async_t", 32'(MDIO_T), 32'd1);
        #9;
        AXI_Rstn = 1'b1;
        hit_rst = 1'b1;
        model_clear();
      end
    end
    if (!hit_rst) begin
      if (acc && is_rd) begin
        got = '0;
        for (int k = 0; k < 16; k++) got = {got[14:0], os[3+k]};
        chk("rd_data", 32'(got), 32'(exp));
        chk("ta_t_o", 32'({ts[0], ts[1], ts[2], os[2]}), 32'b1100);
        chk("rd_drive_t", 32'(ts[18:3]), 32'h0);
        chk("release_t", 32'(ts[19]), 32'd1);
      end else begin
        chk("no_drive_t", 32'(ts), 32'hFFFFF);
      end
    end
    exp_s = acc && is_wr && ta == 2'b10;
    exp_e = acc && ((!is_rd && !is_wr) || (is_wr && ta != 2'b10));
    chk("wr_strb_cnt", 32'(n_strb - s0), 32'(exp_s));
    chk("frame_err_cnt", 32'(n_err - e0), 32'(exp_e));
    if (exp_s) begin
      chk("wr_addr", 32'(last_wa), 32'(ra));
      model_wr(ra, wd);
    end
    chk("ctrl_reg", 32'(Ctrl_Reg), 32'(mregs[0]));
  endtask

  initial begin
    int r;
    logic [1:0] op, ta;
    logic [4:0] phy, ra;
    model_clear();
    #32;
    chk("rst_mdio_t", 32'(MDIO_T), 32'd1);
    chk("rst_mdio_o", 32'(MDIO_O), 32'd1);
    chk("rst_wr_strb", 32'(Wr_Strb), 32'd0);
    chk("rst_wr_addr", 32'(Wr_Addr), 32'd0);
    chk("rst_frame_err", 32'(Frame_Err), 32'd0);
    chk("rst_ctrl", 32'(Ctrl_Reg), 32'd0);
    AXI_Rstn = 1'b1;
    #20;
    frame(32, 2'b01, 5'd1, 5'd4, 2'b10, 16'hA5A5, -1);
    frame(32, 2'b10, 5'd1, 5'd4, 2'b11, 16'h0000, -1);
    frame(32, 2'b10, 5'd1, 5'd2, 2'b11, 16'h0000, -1);
    frame(32, 2'b10, 5'd1, 5'd3, 2'b11, 16'h0000, -1);
    frame(32, 2'b01, 5'd1, 5'd2, 2'b10, 16'hFFFF, -1);
    frame(32, 2'b10, 5'd1, 5'd2, 2'b11, 16'h0000, -1);
    frame(32, 2'b10, 5'd5, 5'd4, 2'b11, 16'h0000, -1);
    frame(32, 2'b10, 5'd1, 5'd4, 2'b11, 16'h0000, -1);
    frame(31, 2'b10, 5'd1, 5'd3, 2'b11, 16'h0000, -1);
    frame(32, 2'b11, 5'd1, 5'd4, 2'b11, 16'h0000, -1);
    frame(32, 2'b01, 5'd1, 5'd5, 2'b11, 16'h1111, -1);
    frame(32, 2'b10, 5'd1, 5'd5, 2'b11, 16'h0000, -1);
    frame(32, 2'b01, 5'd1, 5'd4, 2'b10, 16'h1234, -1);
    frame(32, 2'b01, 5'd1, 5'd0, 2'b10, 16'h8000, -1);
    frame(32, 2'b10, 5'd1, 5'd4, 2'b11, 16'h0000, -1);
    frame(32, 2'b10, 5'd1, 5'd1, 2'b11, 16'h0000, -1);
    frame(32, 2'b01, 5'd1, 5'd6, 2'b10, 16'hBEEF, -1);
    frame(32, 2'b10, 5'd1, 5'd6, 2'b11, 16'h0000, 10);
    frame(32, 2'b10, 5'd1, 5'd6, 2'b11, 16'h0000, -1);
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 15);
      op = r < 7 ? 2'b10 : r < 14 ? 2'b01 : r == 14 ? 2'b00 : 2'b11;
      phy = ($urandom_range(0, 7) == 0) ? 5'($urandom) : PHY;
      ra = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(4, 7));
      ta = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b10;
      frame(($urandom_range(0, 7) == 0) ? 31 : 32, op, phy, ra, ta, 16'($urandom), -1);
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
